fibonacci_index: RTL and testbench



---
 rtl/fib_pkg.sv | 19 +
 rtl/fibonacci_index.sv | 155 +++++++++++++++
 tb/tb_fibonacci_index.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared definitions for the Fibonacci generator / index decoder pair.
//   state_t      : controller states of the index decoder
//   FIB_WIDTH    : default data width of values and Fibonacci registers
//   FIB_MAX_IDX  : largest index n whose F(n) fits in FIB_WIDTH bits
// -----------------------------------------------------------------------------
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int FIB_WIDTH   = 16;
  localparam int FIB_MAX_IDX = 24;  // F(24)=46368, F(25)=75025 > 65535

endpackage : fib_pkg

// File: rtl/fibonacci_index.sv
// -----------------------------------------------------------------------------
// fibonacci_index
// Inverse of the Fibonacci generator: for a value V finds the smallest index
// n >= 1 with F(n) >= V (n = 0 for V = 0), flags an exact hit, and flags when
// no representable F(n) reaches V. Start/done level handshake.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   din      in   value V, captured when a search starts in IDLE
//   start    in   request level; rising in IDLE begins a search,
//                 dropping in DONE acknowledges the result
//   dout     out  resulting index n (0 unless done)
//   exact    out  F(n) == V (0 unless done)
//   ovf      out  V exceeds every representable F(n) (0 unless done)
//   done     out  result valid
//   busy     out  search in progress
// -----------------------------------------------------------------------------
module fibonacci_index
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             exact,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;       // F(idx-1)
  logic [WIDTH-1:0] r_b;       // F(idx)
  logic [WIDTH-1:0] r_idx;
  logic [WIDTH-1:0] r_target;
  logic             r_exact;
  logic             r_ovf;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_idx_next;
  logic [WIDTH-1:0] w_target_next;
  logic             w_exact_next;
  logic             w_ovf_next;

  // One bit wider than the operands so the carry reveals that the next
  // Fibonacci number no longer fits.
  logic [WIDTH:0]   w_sum;
  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  // ---------------------------------------------------------------------------
  // Next-state / next-data logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_idx_next    = r_idx;
    w_target_next = r_target;
    w_exact_next  = r_exact;
    w_ovf_next    = r_ovf;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_target_next = din;
          w_a_next      = '0;
          w_b_next      = WIDTH'(1);
          w_idx_next    = WIDTH'(1);
          w_exact_next  = 1'b0;
          w_ovf_next    = 1'b0;
          w_state_next  = SEARCH;
        end
      end

      SEARCH: begin
        if (r_target == '0) begin
          // F(0)=0 is the only index that matches zero.
          w_idx_next   = '0;
          w_exact_next = 1'b1;
          w_ovf_next   = 1'b0;
          w_state_next = DONE;
        end else if (r_b >= r_target) begin
          w_exact_next = (r_b == r_target);
          w_ovf_next   = 1'b0;
          w_state_next = DONE;
        end else if (w_sum[WIDTH]) begin
          // idx stays at the last index whose F(idx) is representable.
          w_exact_next = 1'b0;
          w_ovf_next   = 1'b1;
          w_state_next = DONE;
        end else begin
          w_a_next   = r_b;
          w_b_next   = w_sum[WIDTH-1:0];
          w_idx_next = r_idx + WIDTH'(1);
        end
      end

      DONE: begin
        // Holding start keeps the result; a new search needs a fresh rise.
        if (!start) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next  = IDLE;
        w_a_next      = '0;
        w_b_next      = '0;
        w_idx_next    = '0;
        w_target_next = '0;
        w_exact_next  = 1'b0;
        w_ovf_next    = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_idx    <= '0;
      r_target <= '0;
      r_exact  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_idx    <= w_idx_next;
      r_target <= w_target_next;
      r_exact  <= w_exact_next;
      r_ovf    <= w_ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, forced to zero outside DONE.
  // ---------------------------------------------------------------------------
  assign done  = (r_state == DONE);
  assign busy  = (r_state == SEARCH);
  assign dout  = done ? r_idx : '0;
  assign exact = done & r_exact;
  assign ovf   = done & r_ovf;

endmodule : fibonacci_index

// File: tb/tb_fibonacci_index.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_index
// Directed vectors with hand-computed indices, latencies and flags for the
// Fibonacci index decoder, including reset mid-search and held-start cases.
// -----------------------------------------------------------------------------
module tb_fibonacci_index;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] din;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             exact;
  logic             ovf;
  logic             done;
  logic             busy;

  int n_checks;
  int n_errors;

  fibonacci_index #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .start   (start),
    .dout    (dout),
    .exact   (exact),
    .ovf     (ovf),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Launch a search for v, wait for done (bounded), check latency and result,
  // optionally wiggle din during the search and hold start through DONE,
  // then release start and check the outputs clear.
  task automatic run_search(input logic [WIDTH-1:0] v, input int exp_idx,
                            input logic exp_exact, input logic exp_ovf,
                            input int exp_lat, input bit wiggle, input int hold);
    int edges;
    @(negedge clk);
    din   = v;
    start = 1'b1;
    edges = 0;
    while (edges < 60) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
      if (wiggle) din = din ^ 16'hA5C3;
    end
    check($sformatf("V=%0d done", v), 32'(done), 32'd1);
    check($sformatf("V=%0d latency", v), 32'(edges), 32'(exp_lat));
    check($sformatf("V=%0d dout", v), 32'(dout), 32'(exp_idx));
    check($sformatf("V=%0d exact", v), 32'(exact), 32'(exp_exact));
    check($sformatf("V=%0d ovf", v), 32'(ovf), 32'(exp_ovf));
    check($sformatf("V=%0d busy", v), 32'(busy), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("V=%0d hold%0d done", v, i), 32'(done), 32'd1);
      check($sformatf("V=%0d hold%0d busy", v, i), 32'(busy), 32'd0);
      check($sformatf("V=%0d hold%0d dout", v, i), 32'(dout), 32'(exp_idx));
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("V=%0d release done", v), 32'(done), 32'd0);
    check($sformatf("V=%0d release dout", v), 32'(dout), 32'd0);
    $display("search V=%0d -> dout=%0d exact=%0d ovf=%0d latency=%0d", v, exp_idx, exp_exact, exp_ovf, edges);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    din      = '0;
    start    = 1'b0;
    #1;
    check("reset dout", 32'(dout), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset asserted mid-search.
    @(negedge clk);
    din   = 16'd1000;
    start = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mid-search busy before reset", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset dout", 32'(dout), 32'd0);
    check("async reset flags", 32'({exact, ovf}), 32'd0);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset mid-search -> outputs cleared");
    run_search(16'd8, 6, 1'b1, 1'b0, 7, 1'b0, 0);

    // Main vectors.
    run_search(16'd55,    10, 1'b1, 1'b0, 11, 1'b0, 0);
    run_search(16'd100,   12, 1'b0, 1'b0, 13, 1'b0, 0);
    run_search(16'd0,      0, 1'b1, 1'b0,  2, 1'b0, 0);
    run_search(16'd1,      1, 1'b1, 1'b0,  2, 1'b0, 0);
    run_search(16'd2,      3, 1'b1, 1'b0,  4, 1'b0, 0);
    run_search(16'd4,      5, 1'b0, 1'b0,  6, 1'b0, 0);
    run_search(16'd46368, 24, 1'b1, 1'b0, 25, 1'b0, 0);
    run_search(16'd46369, 24, 1'b0, 1'b1, 25, 1'b0, 0);
    run_search(16'd50000, 24, 0, 1'b1, 25, 1'b0, 0);
    run_search(16'd65535, 24, 1'b0, 1'b1, 25, 1'b0, 0);

    // din wiggled during search, start held through DONE for 10 cycles.
    run_search(16'd21, 8, 1'b1, 1'b0, 9, 1'b1, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fibonacci_index
